seq_det_prog_7seg: RTL and testbench



---
 rtl/seq_det_prog_7seg.sv | 113 +++++++++++
 tb/tb_seq_det_prog_7seg.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seq_det_prog_7seg.sv
// Programmable serial pattern detector with a saturating hit counter shown on a 7-segment digit.
// Optional SEG_TEST_EN adds a raw segment test override (test_en/test_seg).
module seq_det_prog_7seg #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             overlap,
    input  logic             cnt_clr,
    input  logic             test_en,
    input  logic [7:0]       test_seg,
    output logic             hit,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [7:0]       seg
);

    localparam logic [LEN_W-1:0] PAT_MAX = LEN_W'(PAT_W);

    logic [PAT_W-1:0] pat_q, hist_q, hist_d, mask;
    logic [LEN_W-1:0] len_q, fill_q, fill_d, eff_len;
    logic             sample, match;
    logic             hit_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       seg_q, seg_d;
    logic [2:0]       dp_q;
    logic [6:0]       glyph;

    always_comb begin
        sample  = bit_vld & ~cfg_load;
        eff_len = (len_q > PAT_MAX) ? PAT_MAX : len_q;
        hist_d  = {hist_q[PAT_W-2:0], bit_in};
        fill_d  = (fill_q >= PAT_MAX) ? PAT_MAX : fill_q + 1'b1;
        mask    = ~({PAT_W{1'b1}} << eff_len);
        match   = sample && (eff_len != '0) && (fill_d >= eff_len)
                  && ((hist_d & mask) == (pat_q & mask));
    end

    always_comb begin
        glyph = 7'b1111110;
        unique case (cnt_q[3:0])
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b1100000;
            4'h2: glyph = 7'b0110111;
            4'h3: glyph = 7'b1110011;
            4'h4: glyph = 7'b1101001;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1111101;
            4'hB: glyph = 7'b1001111;
            4'hC: glyph = 7'b0011110;
            4'hD: glyph = 7'b1100111;
            4'hE: glyph = 7'b0011111;
            4'hF: glyph = 7'b0011101;
        endcase
    end

`ifdef SEG_TEST_EN
    assign seg_d = test_en ? test_seg : {glyph, dp_q != 3'd0};
`else
    logic unused_test;
    assign unused_test = ^{test_en, test_seg};
    assign seg_d = {glyph, dp_q != 3'd0};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            len_q  <= '0;
            hist_q <= '0;
            fill_q <= '0;
            hit_q  <= 1'b0;
            cnt_q  <= '0;
            dp_q   <= 3'd0;
            seg_q  <= 8'b11111100;
        end else begin
            hit_q <= match;
            seg_q <= seg_d;
            if (cfg_load) begin
                pat_q  <= cfg_pat;
                len_q  <= cfg_len;
                hist_q <= '0;
                fill_q <= '0;
            end else if (bit_vld) begin
                hist_q <= hist_d;
                fill_q <= (match && !overlap) ? '0 : fill_d;
            end
            // counter and dp stretch advance together with hit
            if (cnt_clr)
                cnt_q <= '0;
            else if (match && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
            if (match)
                dp_q <= 3'd4;
            else if (dp_q != 3'd0)
                dp_q <= dp_q - 1'b1;
        end
    end

    assign hit     = hit_q;
    assign hit_cnt = cnt_q;
    assign seg     = seg_q;

endmodule

// File: tb/tb_seq_det_prog_7seg.sv
// Directed bench for seq_det_prog_7seg (CNT_W=4 so saturation is reachable).
// Checks hits, counter, display glyphs, dp stretch and priority cases.
module tb_seq_det_prog_7seg;

    localparam int PAT_W = 8;
    localparam int CNT_W = 4;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bit_in = 1'b0, bit_vld = 1'b0, cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pat = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             overlap = 1'b0, cnt_clr = 1'b0, test_en = 1'b0;
    logic [7:0]       test_seg = 8'h00;
    logic             hit;
    logic [CNT_W-1:0] hit_cnt;
    logic [7:0]       seg;

    int passed = 0;
    int total  = 0;

    seq_det_prog_7seg #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .overlap(overlap), .cnt_clr(cnt_clr), .test_en(test_en),
        .test_seg(test_seg), .hit(hit), .hit_cnt(hit_cnt), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic exp_hit);
        @(negedge clk);
        bit_in  = b;
        bit_vld = 1'b1;
        @(posedge clk);
        #1;
        bit_vld = 1'b0;
        chk("hit", {31'b0, hit}, {31'b0, exp_hit});
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov);
        @(negedge clk);
        cfg_pat  = p;
        cfg_len  = l;
        overlap  = ov;
        cfg_load = 1'b1;
        cnt_clr  = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    initial begin
        tick(2);
        chk("rst_seg", {24'b0, seg}, 32'hFC);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("idle_seg", {24'b0, seg}, 32'hFC);
            chk("idle_hit", {31'b0, hit}, 32'd0);
            chk("idle_cnt", {28'b0, hit_cnt}, 32'd0);
        end

        // overlapping 1001 on 1001001
        cfg(8'b1001, 4'd4, 1'b1);
        send(1, 0); send(0, 0); send(0, 0); send(1, 1);
        send(0, 0); send(0, 0); send(1, 1);
        chk("ov_cnt", {28'b0, hit_cnt}, 32'd2);
        tick(1);
        chk("ov_seg", {24'b0, seg}, 32'b01101111);
        tick(3);
        chk("ov_dp_last", {24'b0, seg}, 32'b01101111);
        tick(1);
        chk("ov_dp_off", {24'b0, seg}, 32'b01101110);

        // non-overlapping
        cfg(8'b1001, 4'd4, 1'b0);
        send(1, 0); send(0, 0); send(0, 0); send(1, 1);
        send(0, 0); send(0, 0); send(1, 0);
        chk("nov_cnt", {28'b0, hit_cnt}, 32'd1);
        tick(1);
        chk("nov_glyph", {25'b0, seg[7:1]}, 32'b1100000);

        // short pattern 11
        cfg(8'b11, 4'd2, 1'b1);
        send(1, 0); send(1, 1); send(1, 1); send(1, 1); send(1, 1);
        chk("short_ov_cnt", {28'b0, hit_cnt}, 32'd4);
        cfg(8'b11, 4'd2, 1'b0);
        send(1, 0); send(1, 1); send(1, 0); send(1, 1); send(1, 0);
        chk("short_nov_cnt", {28'b0, hit_cnt}, 32'd2);

        // cfg_load discards a completing sample and clears history
        cfg(8'b1001, 4'd4, 1'b1);
        send(1, 0); send(0, 0); send(0, 0);
        @(negedge clk);
        bit_in = 1'b1; bit_vld = 1'b1; cfg_load = 1'b1;
        @(posedge clk);
        #1;
        bit_vld = 1'b0; cfg_load = 1'b0;
        chk("load_hit", {31'b0, hit}, 32'd0);
        send(0, 0); send(0, 0); send(1, 0);
        send(1, 0); send(0, 0); send(0, 0); send(1, 1);
        chk("load_cnt", {28'b0, hit_cnt}, 32'd1);

        // cnt_clr beats a same-cycle hit
        send(0, 0); send(0, 0);
        @(negedge clk);
        bit_in = 1'b1; bit_vld = 1'b1; cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        bit_vld = 1'b0; cnt_clr = 1'b0;
        chk("clr_hit", {31'b0, hit}, 32'd1);
        chk("clr_cnt", {28'b0, hit_cnt}, 32'd0);

        // length zero disables detection
        cfg(8'h00, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) send(i[0], 0);
        chk("len0_cnt", {28'b0, hit_cnt}, 32'd0);

        // saturation with 20 hits
        cfg(8'b11, 4'd2, 1'b1);
        send(1, 0);
        for (int i = 0; i < 20; i++) send(1, 1);
        chk("sat_cnt", {28'b0, hit_cnt}, 32'hF);
        tick(1);
        chk("sat_seg", {24'b0, seg}, 32'b00111011);

        @(negedge clk);
        test_en = 1'b1; test_seg = 8'hA5;
        @(posedge clk);
        #1;
        test_en = 1'b0;
`ifdef SEG_TEST_EN
        chk("test_seg", {24'b0, seg}, 32'hA5);
`else
        chk("test_ignored", {24'b0, seg}, 32'b00111011);
`endif
        tick(1);
        chk("test_restore", {24'b0, seg}, 32'b00111011);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
